// File: rtl/global_history_ijtc.sv
// global_history_ijtc: GHR-indexed indirect jump target cache, multi-lane lookup with mispredict repair
//   clk, rst                       clock, synchronous active-high reset
//   q_valid/q_ready/q_pc           lane-0 query handshake, lanes at q_pc+4*i
//   r_valid/r_hit/r_dest/r_ckpt    registered per-lane results, one cycle after acceptance
//   dir_valid/dir_taken            speculative history shift
//   rep_*                          history repair and indirect-target training
module global_history_ijtc #(
  parameter int ENTRIES = 256,
  parameter int GHR_LEN = 8,
  parameter int LANES   = 4,
  parameter int TAG_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       q_valid,
  output logic                       q_ready,
  input  logic [31:0]                q_pc,
  output logic                       r_valid,
  output logic [LANES-1:0]           r_hit,
  output logic [LANES*32-1:0]        r_dest,
  output logic [LANES*GHR_LEN-1:0]   r_ckpt,
  input  logic                       dir_valid,
  input  logic                       dir_taken,
  input  logic                       rep_valid,
  input  logic [GHR_LEN-1:0]         rep_ckpt,
  input  logic [31:0]                rep_pc,
  input  logic                       rep_taken,
  input  logic [31:0]                rep_dest,
  input  logic                       rep_is_ind
);
  localparam int IDX_W = $clog2(ENTRIES);
  typedef enum logic {INIT, READY} state_t;
  state_t                     state_q;
  logic [IDX_W-1:0]           cnt_q;
  logic [GHR_LEN-1:0]         ghr_q, ghr_d;
  logic [ENTRIES-1:0]         valid_q;
  logic [TAG_W-1:0]           tag_q [ENTRIES];
  logic [31:0]                dest_q [ENTRIES];
  logic                       r_valid_q;
  logic [LANES-1:0]           r_hit_q, hit_d;
  logic [LANES*32-1:0]        r_dest_q, dest_d;
  logic [LANES*GHR_LEN-1:0]   r_ckpt_q;
  logic                       acc, wr;
  logic [IDX_W-1:0]           widx;
  function automatic logic [IDX_W-1:0] idx_of(input logic [31:0] pc, input logic [GHR_LEN-1:0] g);
    return pc[IDX_W+1:2] ^ IDX_W'(g);
  endfunction
  function automatic logic [TAG_W-1:0] tag_of(input logic [31:0] pc);
    return pc[IDX_W+TAG_W+1:IDX_W+2];
  endfunction
  // rst gates everything combinationally so outputs are quiet in the reset cycle itself
  assign q_ready = state_q == READY && !rst;
  assign acc     = q_valid && q_ready;
  assign wr      = q_ready && rep_valid && rep_is_ind;
  assign widx    = idx_of(rep_pc, rep_ckpt);
  assign r_valid = r_valid_q && !rst;
  assign r_hit   = rst ? '0 : r_hit_q;
  assign r_dest  = rst ? '0 : r_dest_q;
  assign r_ckpt  = rst ? '0 : r_ckpt_q;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [31:0]      pc;
    logic [IDX_W-1:0] idx;
    assign pc  = q_pc + 32'(4 * i);
    assign idx = idx_of(pc, ghr_q);
    assign hit_d[i] = valid_q[idx] && tag_q[idx] == tag_of(pc);
    assign dest_d[32*i +: 32] = hit_d[i] ? dest_q[idx] : pc + 32'd8;
  end
  // repair overrides the speculative shift; history is frozen while sweeping
  always_comb
    ghr_d = !q_ready ? ghr_q :
            rep_valid ? {rep_ckpt[GHR_LEN-2:0], rep_taken} :
            dir_valid ? {ghr_q[GHR_LEN-2:0], dir_taken} : ghr_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= INIT;
      cnt_q     <= '0;
      ghr_q     <= '0;
      r_valid_q <= 1'b0;
      r_hit_q   <= '0;
      r_dest_q  <= '0;
      r_ckpt_q  <= '0;
    end else begin
      ghr_q     <= ghr_d;
      r_valid_q <= acc;
      if (acc) begin
        r_hit_q  <= hit_d;
        r_dest_q <= dest_d;
        r_ckpt_q <= {LANES{ghr_q}};
      end
      if (state_q == INIT) begin
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == IDX_W'(ENTRIES - 1)) state_q <= READY;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && state_q == INIT) valid_q[cnt_q] <= 1'b0;
    else if (wr) valid_q[widx] <= 1'b1;
  end
  always_ff @(posedge clk) begin
    if (wr) begin
      tag_q[widx]  <= tag_of(rep_pc);
      dest_q[widx] <= rep_dest;
    end
  end
endmodule

// File: tb/tb_global_history_ijtc.sv
// tb_global_history_ijtc: directed table-driven checks of global_history_ijtc
module tb_global_history_ijtc;
  localparam logic T = 1'b1, F = 1'b0;
  logic         clk = 0, rst = 0;
  logic         q_valid = 0, q_ready;
  logic [31:0]  q_pc = 0;
  logic         r_valid;
  logic [3:0]   r_hit;
  logic [127:0] r_dest;
  logic [31:0]  r_ckpt;
  logic         dir_valid = 0, dir_taken = 0;
  logic         rep_valid = 0, rep_taken = 0, rep_is_ind = 0;
  logic [7:0]   rep_ckpt = 0;
  logic [31:0]  rep_pc = 0, rep_dest = 0;
  int           ntest = 0, nfail = 0;
  typedef struct {
    logic qv; logic [31:0] pc;
    logic dv, dt;
    logic rv; logic [7:0] rc; logic [31:0] rpc; logic rt; logic [31:0] rd; logic ri;
    logic ev; logic [3:0] eh; logic [127:0] ed; logic [7:0] ec;
  } vec_t;
  vec_t vecs [16];
  global_history_ijtc dut (
    .clk(clk), .rst(rst), .q_valid(q_valid), .q_ready(q_ready), .q_pc(q_pc),
    .r_valid(r_valid), .r_hit(r_hit), .r_dest(r_dest), .r_ckpt(r_ckpt),
    .dir_valid(dir_valid), .dir_taken(dir_taken), .rep_valid(rep_valid),
    .rep_ckpt(rep_ckpt), .rep_pc(rep_pc), .rep_taken(rep_taken),
    .rep_dest(rep_dest), .rep_is_ind(rep_is_ind)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    ntest++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input vec_t v);
    q_valid = v.qv; q_pc = v.pc; dir_valid = v.dv; dir_taken = v.dt;
    rep_valid = v.rv; rep_ckpt = v.rc; rep_pc = v.rpc; rep_taken = v.rt;
    rep_dest = v.rd; rep_is_ind = v.ri;
  endtask
  task automatic idle();
    q_valid = 0; dir_valid = 0; rep_valid = 0; rep_is_ind = 0;
  endtask
  initial begin
    int n;
    vecs[0]  = '{T, 32'h8000_0030, F, F, F, 8'h00, 32'h0, F, 32'h0, F, T, 4'h0,
                 {32'h8000_0044, 32'h8000_0040, 32'h8000_003C, 32'h8000_0038}, 8'h00};
    vecs[1]  = '{T, 32'h8000_0010, F, F, F, 8'h00, 32'h0, F, 32'h0, F, T, 4'h0,
                 {32'h8000_0024, 32'h8000_0020, 32'h8000_001C, 32'h8000_0018}, 8'h00};
    vecs[2]  = '{F, 32'h0, F, F, T, 8'hFF, 32'h8000_0014, T, 32'h8000_1000, T, F, 4'h0, 128'h0, 8'h00};
    vecs[3]  = '{T, 32'h8000_0010, F, F, F, 8'h00, 32'h0, F, 32'h0, F, T, 4'b0010,
                 {32'h8000_0024, 32'h8000_0020, 32'h8000_1000, 32'h8000_0018}, 8'hFF};
    vecs[4]  = '{T, 32'h8000_0410, F, F, F, 8'h00, 32'h0, F, 32'h0, F, T, 4'h0,
                 {32'h8000_0424, 32'h8000_0420, 32'h8000_041C, 32'h8000_0418}, 8'hFF};
    vecs[5]  = '{F, 32'h0, F, F, T, 8'h00, 32'h8000_0014, F, 32'h1234_5678, F, F, 4'h0, 128'h0, 8'h00};
    vecs[6]  = '{T, 32'h8000_0010, T, T, T, 8'h81, 32'h8000_0020, F, 32'hCAFE_0000, F, T, 4'h0,
                 {32'h8000_0024, 32'h8000_0020, 32'h8000_001C, 32'h8000_0018}, 8'h00};
    vecs[7]  = '{T, 32'h8000_0010, F, F, F, 8'h00, 32'h0, F, 32'h0, F, T, 4'h0,
                 {32'h8000_0024, 32'h8000_0020, 32'h8000_001C, 32'h8000_0018}, 8'h02};
    vecs[8]  = '{T, 32'h8000_0010, T, T, F, 8'h00, 32'h0, F, 32'h0, F, T, 4'h0,
                 {32'h8000_0024, 32'h8000_0020, 32'h8000_001C, 32'h8000_0018}, 8'h02};
    vecs[9]  = '{T, 32'h8000_0020, F, F, T, 8'h40, 32'h8000_0000, T, 32'h0, F, T, 4'h0,
                 {32'h8000_0034, 32'h8000_0030, 32'h8000_002C, 32'h8000_0028}, 8'h05};
    vecs[10] = '{T, 32'h8000_0020, F, F, F, 8'h00, 32'h0, F, 32'h0, F, T, 4'h0,
                 {32'h8000_0034, 32'h8000_0030, 32'h8000_002C, 32'h8000_0028}, 8'h81};
    vecs[11] = '{T, 32'h8000_0020, F, F, T, 8'h81, 32'h8000_0020, F, 32'h0000_ABCD, T, T, 4'h0,
                 {32'h8000_0034, 32'h8000_0030, 32'h8000_002C, 32'h8000_0028}, 8'h81};
    vecs[12] = '{T, 32'h8000_0020, F, F, T, 8'h40, 32'h0, T, 32'h0, F, T, 4'h0,
                 {32'h8000_0034, 32'h8000_0030, 32'h8000_002C, 32'h8000_0028}, 8'h02};
    vecs[13] = '{T, 32'h8000_0020, F, F, F, 8'h00, 32'h0, F, 32'h0, F, T, 4'b0001,
                 {32'h8000_0034, 32'h8000_0030, 32'h8000_002C, 32'h0000_ABCD}, 8'h81};
    vecs[14] = '{T, 32'hFFFF_FFF0, F, F, F, 8'h00, 32'h0, F, 32'h0, F, T, 4'h0,
                 {32'h0000_0004, 32'h0000_0000, 32'hFFFF_FFFC, 32'hFFFF_FFF8}, 8'h81};
    vecs[15] = '{F, 32'h8000_0020, F, F, F, 8'h00, 32'h0, F, 32'h0, F, F, 4'h0, 128'h0, 8'h00};
    rst = 1;
    repeat (2) tick();
    chk("rst_q_ready", q_ready, 0);
    chk("rst_r_valid", r_valid, 0);
    rst = 0;
    q_valid = 1;
    q_pc = 32'h8000_0010;
    for (int k = 0; k < 256; k++) begin
      chk("init_q_ready", q_ready, 0);
      chk("init_r_valid", r_valid, 0);
      if (k == 250) begin
        rep_valid = 1; rep_is_ind = 1; rep_pc = 32'h8000_0030; rep_ckpt = 0;
        rep_taken = 1; rep_dest = 32'hDEAD_0000;
      end
      if (k == 251) idle();
      if (k == 255) q_valid = 0;
      tick();
    end
    chk("init_done_q_ready", q_ready, 1);
    chk("init_done_r_valid", r_valid, 0);
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i]);
      tick();
      chk($sformatf("v%0d_r_valid", i), r_valid, vecs[i].ev);
      if (vecs[i].ev) begin
        chk($sformatf("v%0d_r_hit", i), r_hit, vecs[i].eh);
        chk($sformatf("v%0d_r_dest", i), r_dest, vecs[i].ed);
        chk($sformatf("v%0d_r_ckpt", i), r_ckpt, {4{vecs[i].ec}});
      end
    end
    idle();
    q_valid = 1; q_pc = 32'h8000_0020;
    tick();
    chk("pre_rst_r_valid", r_valid, 1);
    q_valid = 0;
    rst = 1;
    #1;
    chk("in_rst_r_valid", r_valid, 0);
    chk("in_rst_r_dest", r_dest, 0);
    chk("in_rst_q_ready", q_ready, 0);
    tick();
    rst = 0;
    #1;
    chk("post_rst_r_valid", r_valid, 0);
    chk("post_rst_r_hit", r_hit, 0);
    chk("post_rst_r_dest", r_dest, 0);
    chk("post_rst_r_ckpt", r_ckpt, 0);
    chk("post_rst_q_ready", q_ready, 0);
    n = 0;
    while (!q_ready && n < 300) begin
      tick();
      n++;
    end
    chk("resweep_cycles", n, 256);
    rep_valid = 1; rep_ckpt = 8'h40; rep_taken = 1; rep_is_ind = 0;
    tick();
    idle();
    q_valid = 1; q_pc = 32'h8000_0020;
    tick();
    q_valid = 0;
    chk("resweep_r_valid", r_valid, 1);
    chk("resweep_r_hit", r_hit, 0);
    chk("resweep_r_ckpt", r_ckpt, 32'h8181_8181);
    tick();
    chk("single_cycle_r_valid", r_valid, 0);
    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end
endmodule

// File: doc/global_history_ijtc.md
GLOBAL_HISTORY_IJTC -- requirements
Module: global_history_ijtc

Interface
REQ-001 Parameter ENTRIES, default 256, sets the table depth; it SHALL be a power of two and at least LANES; IDX_W = log2(ENTRIES).
REQ-002 Parameter GHR_LEN, default 8, sets the global history register width; it SHALL be at most IDX_W.
REQ-003 Parameter LANES, default 4, sets the number of consecutive word-aligned instructions predicted per query.
REQ-004 Parameter TAG_W, default 8, sets the tag width per entry.
REQ-005 One clock, clk; reset is synchronous and active-high, rst.
REQ-006 Ports SHALL be:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- q_valid  in  1  query request
- q_ready  out  1  query accepted; low during INIT
- q_pc  in  32  word-aligned PC of lane 0; lane i uses q_pc+4*i
- r_valid  out  1  result valid
- r_hit  out  LANES  per-lane tag hit
- r_dest  out  LANES*32  per-lane predicted target; lane i occupies bits [32i+31:32i]
- r_ckpt  out  LANES*GHR_LEN  per-lane GHR checkpoint
- dir_valid  in  1  front-end direction prediction event
- dir_taken  in  1  predicted direction
- rep_valid  in  1  back-end mispredict repair
- rep_ckpt  in  GHR_LEN  GHR checkpoint of the mispredicted branch
- rep_pc  in  32  PC of the mispredicted branch
- rep_taken  in  1  resolved direction
- rep_dest  in  32  resolved target
- rep_is_ind  in  1  mispredicted branch is an indirect jump

Function
REQ-007 Each entry SHALL hold valid (1), tag (TAG_W) and dest (32).
REQ-008 Index SHALL be pc[IDX_W+1:2] XOR the GHR zero-extended to IDX_W; tag SHALL be pc[IDX_W+TAG_W+1:IDX_W+2].
REQ-009 FSM SHALL have states INIT and READY; rst forces INIT with the sweep counter at 0.
- INIT: clear valid[counter] each cycle; enter READY after clearing entry ENTRIES-1.
- q_ready is 0 in INIT and 1 in READY.
REQ-010 During INIT, q_valid, dir_valid and rep_valid SHALL be ignored.
REQ-011 A query SHALL be accepted when q_valid && q_ready (cycle N); r_valid SHALL be 1 in cycle N+1 only, with results registered.
REQ-012 Per lane i:
- r_hit[i] = valid && tag match.
- r_dest lane i = entry dest on a hit, otherwise q_pc+4*i+8.
- r_ckpt lane i = GHR value at cycle N.
REQ-013 Lookup SHALL use the GHR register value at cycle N, before any same-cycle GHR update.
REQ-014 When dir_valid is asserted without rep_valid: GHR <= {GHR[GHR_LEN-2:0], dir_taken}.
REQ-015 When rep_valid is asserted: GHR <= {rep_ckpt[GHR_LEN-2:0], rep_taken}; dir_valid SHALL be ignored that cycle (repair has priority).
REQ-016 When rep_valid && rep_is_ind: write the entry at the index from rep_pc and rep_ckpt with valid=1, tag(rep_pc), dest=rep_dest.
REQ-017 When rep_is_ind=0: the table SHALL NOT be written.
REQ-018 A query and a table write to the same index in the same cycle SHALL return the old entry (read-before-write); the new data is visible from the next query.
REQ-019 Address arithmetic SHALL be modulo 2^32 (wrap-around, no saturation).

Reset
REQ-020 In a rst cycle, and the cycle after it: r_valid=0, r_hit=0, r_dest=0, r_ckpt=0, GHR=0, q_ready=0.
REQ-021 rst asserted mid-INIT or mid-READY SHALL restart the sweep at entry 0.
REQ-022 All valid bits SHALL read 0 after the sweep completes.

Verification (defaults)
REQ-023 Reset: rst=1 for 2 cycles, then release -> q_ready stays 0 for 256 cycles, then 1; r_valid=0 throughout.
REQ-024 Miss: GHR=0x00, query q_pc=0x8000_0010 -> next cycle r_valid=1, r_hit=4'b0000, lane0 dest 0x8000_0018, lane3 dest 0x8000_0024, all ckpt 0x00.
REQ-025 Repair then hit: rep pc=0x8000_0014, ckpt=0xFF, taken=1, dest=0x8000_1000, is_ind=1 -> GHR=0xFF; then query 0x8000_0010 -> r_hit=4'b0010, lane1 dest 0x8000_1000, ckpt 0xFF.
REQ-026 Tag mismatch: after REQ-025, query 0x8000_0410 -> r_hit=0, lane1 dest 0x8000_041C.
REQ-027 Priority: GHR=0x00, dir_valid=1 (taken=1) together with rep ckpt=0x81, taken=0, is_ind=0 -> GHR=0x02 and no table write.
REQ-028 Query during INIT: q_valid=1 -> no r_valid; repair during INIT -> GHR stays 0 and no write.
